// File: rtl/alu_result_buffer.sv
// alu_result_buffer: two-entry elastic buffer between the ALU and writeback.
// Holds each ALU result with its static field (write-enable + destination)
// and forwards pending writes to decode.
module alu_result_buffer #(
  parameter int unsigned OPERAND_SIZE     = 32,
  parameter int unsigned REG_ADDRESS_SIZE = 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OPERAND_SIZE-1:0]     in_result,
  input  logic [REG_ADDRESS_SIZE:0]   in_static,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OPERAND_SIZE-1:0]     out_result,
  output logic [REG_ADDRESS_SIZE:0]   out_static,
  input  logic                        flush,
  input  logic [REG_ADDRESS_SIZE-1:0] fwd_addr_a,
  input  logic [REG_ADDRESS_SIZE-1:0] fwd_addr_b,
  output logic                        fwd_hit_a,
  output logic                        fwd_hit_b,
  output logic [OPERAND_SIZE-1:0]     fwd_data_a,
  output logic [OPERAND_SIZE-1:0]     fwd_data_b,
  output logic [1:0]                  count
);

  localparam int unsigned STATIC_SIZE = REG_ADDRESS_SIZE + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    head_q;
  logic [OPERAND_SIZE-1:0] result_q [2];
  logic [STATIC_SIZE-1:0]  static_q [2];

  logic push_c;
  logic pop_c;
  logic tail_c;
  logic wr_idx_c;

  // Handshake decode; ready/valid depend on occupancy only.
  assign in_ready = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign count = 2'(state_q);
  assign push_c = in_valid & in_ready;
  assign pop_c = out_valid & out_ready;
  assign tail_c = ~head_q;
  // An empty buffer writes at the head slot; otherwise the slot behind it.
  assign wr_idx_c = (state_q == EMPTY) ? head_q : tail_c;

  assign out_result = result_q[head_q];
  assign out_static = static_q[head_q];

  // Occupancy state and head pointer; flush overrides push and pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      head_q  <= 1'b0;
    end else if (flush) begin
      state_q <= EMPTY;
      head_q  <= 1'b0;
    end else begin
      if (pop_c) begin
        head_q <= ~head_q;
      end
      unique case (state_q)
        EMPTY: if (push_c) state_q <= ONE;
        ONE: begin
          if (push_c && !pop_c) begin
            state_q <= FULL;
          end else if (pop_c && !push_c) begin
            state_q <= EMPTY;
          end
        end
        FULL: if (pop_c) state_q <= ONE;
        default: state_q <= EMPTY;
      endcase
    end
  end

  // Entry storage; written only on an accepted, non-flushed push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q[0] <= '0;
      result_q[1] <= '0;
      static_q[0] <= '0;
      static_q[1] <= '0;
    end else if (push_c && !flush) begin
      result_q[wr_idx_c] <= in_result;
      static_q[wr_idx_c] <= in_static;
    end
  end

  function automatic logic fwd_match(input logic [STATIC_SIZE-1:0] st,
                                     input logic [REG_ADDRESS_SIZE-1:0] addr);
    return st[REG_ADDRESS_SIZE] && (st[REG_ADDRESS_SIZE-1:0] == addr) && (addr != '0);
  endfunction

  // Forwarding from stored entries; the younger (tail) entry wins.
  always_comb begin
    logic head_a, tail_a, head_b, tail_b;
    head_a = out_valid && fwd_match(static_q[head_q], fwd_addr_a);
    tail_a = (state_q == FULL) && fwd_match(static_q[tail_c], fwd_addr_a);
    head_b = out_valid && fwd_match(static_q[head_q], fwd_addr_b);
    tail_b = (state_q == FULL) && fwd_match(static_q[tail_c], fwd_addr_b);
    fwd_hit_a  = head_a | tail_a;
    fwd_hit_b  = head_b | tail_b;
    fwd_data_a = '0;
    fwd_data_b = '0;
    if (tail_a) begin
      fwd_data_a = result_q[tail_c];
    end else if (head_a) begin
      fwd_data_a = result_q[head_q];
    end
    if (tail_b) begin
      fwd_data_b = result_q[tail_c];
    end else if (head_b) begin
      fwd_data_b = result_q[head_q];
    end
  end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Two-entry elastic buffer directly downstream of the ALU in the execute stage. It captures each ALU result together with its static destination field (write-enable plus destination register address) and holds them until the writeback stage accepts them, decoupling ALU issue from writeback stalls with a valid/ready handshake. It also supplies operand-forwarding data for results that have not yet been written back, and supports a pipeline flush.

## Interface

Parameters:
- OPERAND_SIZE, 32, width of ALU result data.
- REG_ADDRESS_SIZE, 5, width of a register address. The static field is REG_ADDRESS_SIZE+1 bits wide: bit [REG_ADDRESS_SIZE] is write-enable, bits [REG_ADDRESS_SIZE-1:0] are the destination address.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU side holds a result.
- in_ready  output  1  buffer can accept; high exactly when count < 2.
- in_result  input  OPERAND_SIZE  ALU result.
- in_static  input  REG_ADDRESS_SIZE+1  static field passed through by the ALU.
- out_valid  output  1  head entry valid; high exactly when count > 0.
- out_ready  input  1  writeback accepts the head entry.
- out_result  output  OPERAND_SIZE  head entry result.
- out_static  output  REG_ADDRESS_SIZE+1  head entry static field.
- flush  input  1  synchronous discard of all entries.
- fwd_addr_a, fwd_addr_b  input  REG_ADDRESS_SIZE  source register addresses from decode.
- fwd_hit_a, fwd_hit_b  output  1  matching pending write exists.
- fwd_data_a, fwd_data_b  output  OPERAND_SIZE  forwarded value; 0 when no hit.
- count  output  2  occupancy, 0..2.

## Operation

- States, encoded by count: EMPTY (0), ONE (1), FULL (2). Storage is two entry registers (result + static) plus a 1-bit head pointer.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- EMPTY: push -> ONE. No push -> EMPTY.
- ONE: push & pop -> ONE (the new entry becomes head). Push only -> FULL. Pop only -> EMPTY. Neither -> ONE.
- FULL: pop -> ONE and the head pointer advances. in_ready = 0, so no push is possible.
- in_ready depends only on count, never on out_ready. There is no combinational path from in_* to out_*, or from out_ready to in_ready.
- Ordering is strict FIFO. Entries are stored unmodified, including entries whose write-enable is 0.
- Flush: on the next edge, count becomes 0 and the head pointer becomes 0. Flush takes priority over a simultaneous push and pop. The push is dropped, and the popped entry counts as delivered to writeback that cycle.
- Forwarding is combinational from stored state only. An entry matches port x when all of the following hold:
  - the entry is valid;
  - its write-enable bit is 1;
  - its destination address equals fwd_addr_x;
  - fwd_addr_x != 0 (register 0 is never forwarded).
- If both entries match, the younger (tail) entry supplies fwd_data_x. With no match, fwd_hit_x = 0 and fwd_data_x = 0. The in_* values are not forwarded.
- Data registers hold their last value when not written. out_result and out_static are don't-care while out_valid = 0.

## Timing

- Reset (reset_n low, asynchronous) sets count = 0, head pointer = 0 and all entry registers = 0. Outputs: in_ready = 1, out_valid = 0, out_result = 0, out_static = 0, fwd_hit_* = 0, fwd_data_* = 0. Reset deassertion is synchronized externally.
- Latency: a result accepted at edge N appears on out_* with out_valid = 1 immediately after edge N (registered output, one cycle).
- Throughput: one result per cycle when out_ready is held high.
- Asserting reset_n low mid-transfer discards all entries immediately, without waiting for a clock edge.
- Forwarding outputs reflect state after the most recent edge, so they are stable for the whole cycle.

## Test plan

- Reset then idle. Drive reset_n = 0 asynchronously, then release -> count = 0, in_ready = 1, out_valid = 0, fwd_hit_a = 0.
- Streaming. Push results 0x11, 0x22, 0x33 with static 0x21, 0x22, 0x23 on consecutive cycles, with out_ready = 1 -> out_result is 0x11, 0x22, 0x33 on the following cycles and count stays 1.
- Backpressure. Set out_ready = 0 and push 0xA then 0xB -> count = 2 and in_ready = 0. A third push of 0xC is not accepted. Then set out_ready = 1 -> 0xA then 0xB emerge, and in_ready returns to 1 after the first pop.
- Forwarding priority. Hold both entries with static {1, 5}, values 0x100 (older) and 0x200 (younger). Set fwd_addr_a = 5 -> fwd_hit_a = 1, fwd_data_a = 0x200. Set fwd_addr_b = 0 while an entry with static {1, 0} is held -> fwd_hit_b = 0. An entry with write-enable 0 also gives no hit.
- Flush collision. With count = 1, assert flush, in_valid and out_ready in the same cycle -> the head pops once, the pushed value is dropped, and count = 0 afterwards.
- Asynchronous reset while FULL. Pull reset_n low between clock edges -> out_valid falls before the next edge, and count = 0.
